// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stall/flush steering, exec-stage forwarding, memory-stall watchdog, ECALL halt.
// Optional HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic                  i_load_instr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic                  i_reg_we_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_reg_we_wb,
  input  logic                  i_mispredict_exec,
  input  logic                  i_ecall_exec,
  input  logic                  i_icache_stall,
  input  logic                  i_dcache_stall,
  output logic                  o_stall_fetch,
  output logic                  o_stall_dec,
  output logic                  o_stall_exec,
  output logic                  o_stall_mem,
  output logic                  o_flush_dec,
  output logic                  o_flush_exec,
  output logic [1:0]            o_forward_rs1,
  output logic [1:0]            o_forward_rs2,
  output logic                  o_halt,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_flush_cnt,
`endif
  output logic                  o_timeout
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  state_t                state, state_nxt;
  logic [TIMEOUT_W-1:0]  wd_cnt;
  logic                  memstall, load_use;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rd_addr_mem == rs))
      return 2'b10;
    else if (i_reg_we_wb && (i_rd_addr_wb != '0) && (i_rd_addr_wb == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign o_forward_rs1 = fwd_sel(i_rs1_addr_exec);
  assign o_forward_rs2 = fwd_sel(i_rs2_addr_exec);

  assign memstall = i_icache_stall | i_dcache_stall;
  assign load_use = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                    ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));

  // Outputs are gated by reset so an in-flight miss cannot leak stalls while reset is held.
  always_comb begin
    state_nxt     = state;
    o_stall_fetch = 1'b0;
    o_stall_dec   = 1'b0;
    o_stall_exec  = 1'b0;
    o_stall_mem   = 1'b0;
    o_flush_dec   = 1'b0;
    o_flush_exec  = 1'b0;
    o_halt        = 1'b0;
    if (!i_arst) begin
      case (state)
        HALT: begin
          o_stall_fetch = 1'b1;
          o_stall_dec   = 1'b1;
          o_stall_exec  = 1'b1;
          o_stall_mem   = 1'b1;
          o_halt        = 1'b1;
        end
        default: begin
          // MEM_WAIT with memstall released behaves exactly like RUN.
          state_nxt = RUN;
          if (memstall) begin
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_stall_exec  = 1'b1;
            o_stall_mem   = 1'b1;
            state_nxt     = MEM_WAIT;
          end else if (i_mispredict_exec) begin
            o_flush_dec  = 1'b1;
            o_flush_exec = 1'b1;
          end else if (i_ecall_exec) begin
            o_stall_fetch = 1'b1;
            o_flush_dec   = 1'b1;
            o_flush_exec  = 1'b1;
            state_nxt     = HALT;
          end else if (load_use) begin
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_flush_exec  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state     <= RUN;
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MEM_WAIT) begin
        if (memstall) begin
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
          if (wd_cnt >= WD_MAX - 1'b1) o_timeout <= 1'b1;
        end else begin
          wd_cnt <= '0;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_any;
  assign stall_any = o_stall_fetch | o_stall_dec | o_stall_exec | o_stall_mem;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (state != HALT) begin
      if (stall_any)    o_stall_cnt <= o_stall_cnt + 32'd1;
      if (o_flush_exec) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT_W=4); expected output vectors go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          arst;
  logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
  logic          load_exec, we_mem, we_wb, mispredict, ecall, icache, dcache;
  logic          stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec, halt, timeout;
  logic [1:0]    fwd1, fwd2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .TIMEOUT_W(4)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec),
    .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec),
    .i_rd_addr_exec(rd_exec), .i_load_instr_exec(load_exec),
    .i_rd_addr_mem(rd_mem), .i_reg_we_mem(we_mem),
    .i_rd_addr_wb(rd_wb), .i_reg_we_wb(we_wb),
    .i_mispredict_exec(mispredict), .i_ecall_exec(ecall),
    .i_icache_stall(icache), .i_dcache_stall(dcache),
    .o_stall_fetch(stall_fetch), .o_stall_dec(stall_dec),
    .o_stall_exec(stall_exec), .o_stall_mem(stall_mem),
    .o_flush_dec(flush_dec), .o_flush_exec(flush_exec),
    .o_forward_rs1(fwd1), .o_forward_rs2(fwd2),
    .o_halt(halt),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt),
`endif
    .o_timeout(timeout)
  );

  // Vector layout: {stall f,d,e,m | flush d,e | fwd1 | fwd2 | halt | timeout}
  function automatic logic [11:0] ev(input logic [3:0] st, input logic [1:0] fl,
                                     input logic [1:0] f1, input logic [1:0] f2,
                                     input logic h, input logic t);
    return {st, fl, f1, f2, h, t};
  endfunction

  task automatic clr();
    {rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb} = '0;
    {load_exec, we_mem, we_wb, mispredict, ecall, icache, dcache} = '0;
  endtask

  task automatic chk(input string tag, input logic [11:0] e);
    exp_t        x;
    logic [11:0] obs;
    q.push_back('{tag, e});
    #1;
    obs = {stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec,
           fwd1, fwd2, halt, timeout};
    x = q.pop_front();
    n_cmp++;
    assert (obs === x.v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    clr();
    arst = 1'b1;
    #2;
    chk("reset", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    step();
    arst = 1'b0;
    step();

    // Forwarding
    rd_mem = 5; we_mem = 1; rd_wb = 5; we_wb = 1; rs1_exec = 5;
    chk("fwd_mem_prio", ev(4'h0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
    rd_mem = 0;
    chk("fwd_mem_x0", ev(4'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0));
    rd_mem = 5; we_mem = 0; rs2_exec = 5;
    chk("fwd_wb_both", ev(4'h0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0));
    rd_wb = 0;
    chk("fwd_wb_x0", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    we_mem = 1; rs1_exec = 9;
    chk("fwd_rs2_mem", ev(4'h0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0));
    clr();
    step();

    // Load-use
    load_exec = 1; rd_exec = 7; rs2_dec = 7;
    chk("load_use", ev(4'hC, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0));
    step();
    clr();
    chk("load_use_after", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    load_exec = 1; rd_exec = 0; rs1_dec = 0;
    chk("load_use_x0", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    step();

    // Mispredict beats load-use
    clr();
    load_exec = 1; rd_exec = 3; rs1_dec = 3; mispredict = 1;
    chk("mispred_lu", ev(4'h0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0));
    step();

    // D-cache stall holds mispredict for 3 cycles, it acts on release
    clr();
    dcache = 1; mispredict = 1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dstall_%0d", k), ev(4'hF, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
      step();
    end
    dcache = 0;
    chk("dstall_release", ev(4'h0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0));
    step();
    clr();
    chk("idle_after", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

    // Watchdog: 15 MEM_WAIT cycles to saturate at TIMEOUT_W=4
    icache = 1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("wd_%0d", k), ev(4'hF, 2'b00, 2'b00, 2'b00, 1'b0, k >= 16));
      step();
    end
    icache = 0;
    chk("wd_release", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    step();
    chk("wd_sticky", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));

    // ECALL held off by memstall, then acts on release and halts
    dcache = 1; ecall = 1;
    chk("ecall_memstall", ev(4'hF, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    step();
    dcache = 0;
    chk("ecall", ev(4'h8, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1));
    step();
    clr();
    mispredict = 1; rd_mem = 3; we_mem = 1; rs2_exec = 3;
    chk("halt", ev(4'hF, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1));
    step();
    clr();
    icache = 1;
    chk("halt_hold", ev(4'hF, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1));
    #2;
    arst = 1'b1;
    chk("halt_arst", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    step();
    arst = 1'b0;
    clr();
    chk("post_reset", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

    // Reset in the middle of a miss
    icache = 1;
    step();
    step();
    chk("miss_pre_rst", ev(4'hF, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    #2;
    arst = 1'b1;
    chk("miss_arst", ev(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    step();
    clr();
    arst = 1'b0;
    step();
    load_exec = 1; rd_exec = 4; rs1_dec = 4;
    chk("run_after_rst", ev(4'hC, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end
endmodule
